// File: rtl/dmem_ctrl_wbuf.sv
// MIPS32 MEM-stage data-memory controller: posted-write buffer, registered req/ack memory FSM,
// big-endian byte lanes, LL/SC reservation tracking and SYNC drain.
module dmem_ctrl_wbuf #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WB_DEPTH   = 4,
  parameter logic [31:0] UMEM_LOWER = 32'h0001_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_read,
  input  logic                req_write,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic                kernel_mode,
  input  logic                llsc,
  input  logic                eret,
  input  logic                sync_req,
  output logic [DATA_W-1:0]   rdata,
  output logic                stall,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                mem_read,
  output logic                mem_write,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]       mem_be_q, mem_be_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                resv_valid_q, resv_valid_d;
  logic [31:0]         resv_addr_q, resv_addr_d;

  logic [31:0]         buf_addr_q [WB_DEPTH];
  logic [DATA_W-1:0]   buf_data_q [WB_DEPTH];
  logic [NB-1:0]       buf_be_q   [WB_DEPTH];

  logic [31:0]         gran_addr;
  logic [3:0]          nbytes, lane_lo;
  logic [15:0]         be_wide;
  logic [NB-1:0]       acc_be;
  logic [DATA_W-1:0]   rep_data, shifted, ld_ext;
  logic                sign_bit, misalign, priv_err, exc;
  logic                ld_ok, st_ok, full, hazard, resv_hit, enq, pop, rd_done;

  assign gran_addr = {addr[31:LW], {LW{1'b0}}};
  assign nbytes    = 4'd1 << size;
  // Big-endian: byte offset 0 sits in the most significant lane.
  assign lane_lo   = 4'(NB) - 4'(addr[LW-1:0]) - nbytes;
  assign be_wide   = ((16'd1 << nbytes) - 16'd1) << lane_lo;
  assign acc_be    = be_wide[NB-1:0];

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'd1:    misalign = addr[0];
      2'd2:    misalign = |addr[1:0];
      2'd3:    misalign = (DATA_W != 64) || (|addr[2:0]);
      default: misalign = 1'b0;
    endcase
  end

  assign priv_err = ~kernel_mode & (addr < UMEM_LOWER);
  assign exc      = misalign | priv_err;
  assign exc_adel = req_read & exc;
  assign exc_ades = req_write & exc;
  assign ld_ok    = req_read & ~exc;
  assign st_ok    = req_write & ~req_read & ~exc;

  assign full     = (count_q == CW'(WB_DEPTH));
  assign resv_hit = resv_valid_q & (resv_addr_q == gran_addr);
  assign enq      = st_ok & ~full & (~llsc | resv_hit);
  assign pop      = (state_q == StWrWait) & mem_ack;
  assign rd_done  = (state_q == StRdWait) & mem_ack;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(WB_DEPTH); i++) begin
      logic [CW-1:0] rel;
      rel = CW'(PW'(i) - rd_ptr_q);
      if (rel < count_q && buf_addr_q[i] == gran_addr) hazard = 1'b1;
    end
  end

  always_comb begin
    case (size)
      2'd0:    rep_data = {NB{wdata[7:0]}};
      2'd1:    rep_data = {(NB / 2){wdata[15:0]}};
      2'd2:    rep_data = {(NB / 4){wdata[31:0]}};
      default: rep_data = wdata;
    endcase
  end

  assign shifted = mem_rdata >> {lane_lo, 3'b000};

  always_comb begin
    case (size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_W-1];
    endcase
    ld_ext = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      ld_ext[i] = (i < 8 * int'(nbytes)) ? shifted[i] : (sign_ext & sign_bit);
    end
  end

  always_comb begin
    rdata = '0;
    if (st_ok && llsc)       rdata = {{(DATA_W - 1){1'b0}}, resv_hit};
    else if (ld_ok && rd_done) rdata = ld_ext;
  end

  always_comb begin
    stall = 1'b0;
    if (ld_ok)      stall = ~rd_done;
    else if (st_ok) stall = full;
    if (sync_req && (count_q != '0 || state_q != StIdle)) stall = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      StIdle: begin
        // A hazard-free load wins over draining the buffer.
        if (ld_ok && !hazard) begin
          state_d     = StRdWait;
          mem_addr_d  = gran_addr;
          mem_wdata_d = '0;
          mem_be_d    = acc_be;
        end else if (count_q != '0) begin
          state_d     = StWrWait;
          mem_addr_d  = buf_addr_q[rd_ptr_q];
          mem_wdata_d = buf_data_q[rd_ptr_q];
          mem_be_d    = buf_be_q[rd_ptr_q];
        end
      end
      StRdWait: if (mem_ack) state_d = StIdle;
      StWrWait: if (mem_ack) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + PW'(enq);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q + CW'(enq) - CW'(pop);
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    if (ld_ok && llsc && rd_done) begin
      resv_valid_d = 1'b1;
      resv_addr_d  = gran_addr;
    end
    if ((enq && resv_hit) || (st_ok && llsc && !full) || eret) resv_valid_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (enq) begin
      buf_addr_q[wr_ptr_q] <= gran_addr;
      buf_data_q[wr_ptr_q] <= rep_data;
      buf_be_q[wr_ptr_q]   <= acc_be;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_read  = (state_q == StRdWait);
  assign mem_write = (state_q == StWrWait);

endmodule

// File: tb/tb_dmem_ctrl_wbuf.sv
// Randomized bench for dmem_ctrl_wbuf (64-bit bus): architectural memory and reservation model
// plus an in-order expected-write queue checked by a memory responder.
module tb_dmem_ctrl_wbuf;

  localparam int unsigned DW = 64;
  localparam int unsigned NB = DW / 8;
  localparam int OP_LD = 0, OP_ST = 1, OP_LL = 2, OP_SC = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_read, req_write, sign_ext, kernel_mode, llsc, eret, sync_req;
  logic [31:0]   addr;
  logic [DW-1:0] wdata, rdata, mem_wdata, mem_rdata;
  logic [1:0]    size;
  logic          stall, exc_adel, exc_ades, mem_read, mem_write, mem_ack;
  logic [31:0]   mem_addr;
  logic [NB-1:0] mem_be;

  dmem_ctrl_wbuf #(.DATA_W(DW), .WB_DEPTH(4), .UMEM_LOWER(32'h0001_0000)) dut (
    .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write), .addr(addr),
    .wdata(wdata), .size(size), .sign_ext(sign_ext), .kernel_mode(kernel_mode), .llsc(llsc),
    .eret(eret), .sync_req(sync_req), .rdata(rdata), .stall(stall), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0]   a;
    logic [NB-1:0] be;
    logic [DW-1:0] d;
  } wr_t;

  logic [7:0]  smem [int unsigned];  // contents of the memory behind the port
  logic [7:0]  rmem [int unsigned];  // architectural memory as seen by the CPU
  wr_t         exp_q [$];
  logic        resv_v;
  logic [31:0] resv_g;

  function automatic logic [7:0] sbyte(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction

  function automatic logic [63:0] model_load(input logic [31:0] a, input int n, input logic sx);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v = (v << 8) | 64'(rbyte(a + 32'(j)));
    if (sx && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input int n, input logic [63:0] d);
    wr_t         e;
    logic [31:0] g;
    int          off;
    g   = a & ~32'(NB - 1);
    off = int'(a - g);
    e.a = g;
    for (int i = 0; i < int'(NB); i++) begin
      int p, j;
      p = int'(NB) - 1 - i;
      j = p % n;
      e.be[i]      = (p >= off) && (p < off + n);
      e.d[8*i +: 8] = 8'(d >> (8 * (n - 1 - j)));
    end
    exp_q.push_back(e);
    for (int j = 0; j < n; j++) rmem[a + 32'(j)] = 8'(d >> (8 * (n - 1 - j)));
    if (resv_v && resv_g == g) resv_v = 1'b0;
  endtask

  // Memory responder: ack policy 0 = random, 1 = tied high, 2 = never.
  int            ack_mode;
  logic          prev_wait, p_rd, p_wr;
  logic [31:0]   p_addr;
  logic [DW-1:0] p_wdata;
  logic [NB-1:0] p_be, last_be;
  logic          ack_v;
  wr_t           r_e;

  always @(posedge clock) begin
    #1;
    if (reset) begin
      mem_ack   = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        check_eq("req_hold", {mem_read, mem_write}, {p_rd, p_wr});
        check_eq("addr_hold", mem_addr, p_addr);
        check_eq("wdata_hold", mem_wdata, p_wdata);
        check_eq("be_hold", mem_be, p_be);
      end
      case (ack_mode)
        0:       ack_v = 1'($urandom_range(0, 1));
        1:       ack_v = 1'b1;
        default: ack_v = 1'b0;
      endcase
      mem_ack = ack_v;
      if (ack_v && mem_write) begin
        check_eq("wr_pending", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          r_e = exp_q.pop_front();
          check_eq("wr_addr", mem_addr, r_e.a);
          check_eq("wr_be", mem_be, r_e.be);
          check_eq("wr_data", mem_wdata, r_e.d);
        end
        for (int i = 0; i < int'(NB); i++)
          if (mem_be[i]) smem[mem_addr + 32'(NB - 1 - i)] = mem_wdata[8*i +: 8];
        last_be = mem_be;
      end
      if (ack_v && mem_read) begin
        check_eq("rd_addr_align", mem_addr % NB, 0);
        for (int i = 0; i < int'(NB); i++) mem_rdata[8*i +: 8] = sbyte(mem_addr + 32'(NB - 1 - i));
      end
      prev_wait = (mem_read | mem_write) & ~ack_v;
      p_rd = mem_read; p_wr = mem_write; p_addr = mem_addr; p_wdata = mem_wdata; p_be = mem_be;
    end
  end

  task automatic cpu_op(input int op, input logic [31:0] a, input logic [1:0] sz,
                        input logic [63:0] d, input logic sx, input logic kern,
                        output logic [63:0] rd, output int cyc);
    logic is_rd, exc, succ;
    int   n;
    logic [31:0] g;
    is_rd = (op == OP_LD) || (op == OP_LL);
    n     = 1 << sz;
    exc   = ((a % n) != 0) || (!kern && a < 32'h0001_0000);
    g     = a & ~32'(NB - 1);
    req_read = is_rd; req_write = !is_rd; addr = a; size = sz; wdata = d; sign_ext = sx;
    kernel_mode = kern; llsc = (op == OP_LL) || (op == OP_SC);
    cyc = 0;
    @(negedge clock);
    while (stall === 1'b1 && cyc < 400) begin
      cyc++;
      @(negedge clock);
    end
    if (stall !== 1'b0) check_eq("op_timeout", stall, 0);
    rd = rdata;
    check_eq("exc_adel", exc_adel, is_rd && exc);
    check_eq("exc_ades", exc_ades, !is_rd && exc);
    if (!exc) begin
      case (op)
        OP_LD, OP_LL: begin
          check_eq("ld_data", rdata, model_load(a, n, sx));
          if (op == OP_LL) begin resv_v = 1'b1; resv_g = g; end
        end
        OP_ST: model_store(a, n, d);
        default: begin
          succ = resv_v && (resv_g == g);
          check_eq("sc_result", rdata, 64'(succ));
          resv_v = 1'b0;
          if (succ) model_store(a, n, d);
        end
      endcase
    end
    @(posedge clock); #1;
    req_read = 1'b0; req_write = 1'b0; llsc = 1'b0;
  endtask

  task automatic do_sync();
    int cyc;
    sync_req = 1'b1;
    cyc = 0;
    @(negedge clock);
    while (stall === 1'b1 && cyc < 400) begin
      cyc++;
      @(negedge clock);
    end
    check_eq("sync_release", stall, 0);
    check_eq("sync_drained", exp_q.size(), 0);
    check_eq("sync_idle", {mem_read, mem_write}, 0);
    @(posedge clock); #1;
    sync_req = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    @(posedge clock); #1;
    eret   = 1'b0;
    resv_v = 1'b0;
  endtask

  logic [63:0] rd_v;
  int          cyc_v;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, last_ll;
    logic [1:0]  sz;
    int          op, r;
    reset = 1'b1; req_read = 0; req_write = 0; addr = '0; wdata = '0; size = '0; sign_ext = 0;
    kernel_mode = 1; llsc = 0; eret = 0; sync_req = 0; mem_ack = 0; mem_rdata = '0;
    ack_mode = 2; resv_v = 0; resv_g = '0; last_be = '0; last_ll = 32'h0001_0000;
    repeat (3) @(negedge clock);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_mem_be", mem_be, 0);
    check_eq("rst_stall", stall, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Reset while a read is outstanding.
    req_read = 1; addr = 32'h0001_0000; size = 2'd2; kernel_mode = 1;
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("rdwait_mem_read", mem_read, 1);
    check_eq("rdwait_stall", stall, 1);
    #2 reset = 1'b1; req_read = 0;
    @(negedge clock);
    check_eq("rst_abort_read", mem_read, 0);
    check_eq("rst_abort_stall", stall, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    sync_req = 1;
    @(negedge clock);
    check_eq("rst_empty_sync", stall, 0);
    @(posedge clock); #1;
    sync_req = 0;

    // Four word stores with ack tied high: none stall, drained in order.
    ack_mode = 1;
    for (int k = 0; k < 4; k++) begin
      cpu_op(OP_ST, 32'h0001_0000 + 32'(4 * k), 2'd2, 64'h1111_0000 + 64'(k), 0, 1, rd_v, cyc_v);
      check_eq("sw_nostall", cyc_v, 0);
    end
    do_sync();

    // Load behind a buffered store to the same granule.
    ack_mode = 0;
    cpu_op(OP_ST, 32'h0001_0004, 2'd2, 64'hDEAD_BEEF, 0, 1, rd_v, cyc_v);
    cpu_op(OP_LD, 32'h0001_0004, 2'd2, 0, 0, 1, rd_v, cyc_v);
    check_eq("lw_after_sw", rd_v, 64'h0000_0000_DEAD_BEEF);
    check_eq("lw_drain_wait", cyc_v >= 3, 1);

    // Byte store lane and signed byte load.
    cpu_op(OP_ST, 32'h0001_0003, 2'd0, 64'hA5, 0, 1, rd_v, cyc_v);
    do_sync();
    check_eq("sb_be", last_be, 8'h10);
    cpu_op(OP_LD, 32'h0001_0003, 2'd0, 0, 1, 1, rd_v, cyc_v);
    check_eq("lb_signed", rd_v, 64'hFFFF_FFFF_FFFF_FFA5);

    // LL/SC: broken by an intervening store, plain success, broken by eret.
    cpu_op(OP_LL, 32'h0001_0008, 2'd2, 0, 0, 1, rd_v, cyc_v);
    cpu_op(OP_ST, 32'h0001_0008, 2'd2, 64'h1234_5678, 0, 1, rd_v, cyc_v);
    cpu_op(OP_SC, 32'h0001_0008, 2'd2, 64'h0BAD_0BAD, 0, 1, rd_v, cyc_v);
    check_eq("sc_after_sw", rd_v, 0);
    do_sync();
    cpu_op(OP_LL, 32'h0001_0010, 2'd2, 0, 0, 1, rd_v, cyc_v);
    cpu_op(OP_SC, 32'h0001_0010, 2'd2, 64'h77, 0, 1, rd_v, cyc_v);
    check_eq("sc_ok", rd_v, 1);
    cpu_op(OP_LL, 32'h0001_0018, 2'd3, 0, 0, 1, rd_v, cyc_v);
    do_eret();
    cpu_op(OP_SC, 32'h0001_0018, 2'd3, 64'h55, 0, 1, rd_v, cyc_v);
    check_eq("sc_after_eret", rd_v, 0);
    do_sync();

    // Address errors never reach memory.
    cpu_op(OP_LD, 32'h0000_0100, 2'd2, 0, 0, 0, rd_v, cyc_v);
    check_eq("exc_nostall", cyc_v, 0);
    @(negedge clock);
    check_eq("exc_no_read", mem_read, 0);
    @(posedge clock); #1;
    cpu_op(OP_ST, 32'h0001_0001, 2'd2, 64'h99, 0, 1, rd_v, cyc_v);
    do_sync();

    // Full buffer: fifth store stalls until memory drains.
    ack_mode = 2;
    for (int k = 0; k < 4; k++) begin
      cpu_op(OP_ST, 32'h0001_0020 + 32'(8 * k), 2'd2, 64'hC0DE_0000 + 64'(k), 0, 1, rd_v, cyc_v);
      check_eq("fill_nostall", cyc_v, 0);
    end
    fork
      cpu_op(OP_ST, 32'h0001_0040, 2'd2, 64'hF00D, 0, 1, rd_v, cyc_v);
      begin
        repeat (4) @(negedge clock);
        check_eq("full_stall", stall, 1);
        ack_mode = 1;
      end
    join
    check_eq("full_wait", cyc_v >= 4, 1);
    ack_mode = 0;
    do_sync();

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) do_eret();
      else if (r < 12) do_sync();
      else begin
        op = int'($urandom_range(0, 3));
        sz = 2'($urandom_range(0, 3));
        a  = 32'h0001_0000 + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 9) != 0) a = a & ~32'((1 << sz) - 1);
        if (op == OP_SC && $urandom_range(0, 1) == 1) a = last_ll;
        if ($urandom_range(0, 19) == 0) a = 32'($urandom_range(0, 255));
        cpu_op(op, a, sz, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0, rd_v, cyc_v);
        if (op == OP_LL) last_ll = a;
      end
    end
    do_sync();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
